alu_serial_sequencer: RTL and testbench

- Bit-serial ALU controller for the execute stage.
- Sequences one shared 1-bit ALU slice (AND/OR/full-adder/SLT select) over WIDTH cycles to produce a full-width result, then flags.
- Serves area-reduced builds where the EX stage stalls on busy.
- Start/busy/done handshake toward the pipeline control.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_bit_slice.sv | 28 ++
 rtl/alu_serial_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_serial_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, sequencer states and slice decode helpers
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SLT_FIX,
        ST_DONE
    } alu_state_e;

    // Output select of the 1-bit slice; SEL_ZERO serves unsupported op codes.
    typedef enum logic [1:0] {
        SEL_AND,
        SEL_OR,
        SEL_SUM,
        SEL_ZERO
    } alu_sel_e;

    // SUB and SLT both run the adder with B inverted and carry-in 1.
    function automatic logic op_uses_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic alu_sel_e op_to_sel(input logic [2:0] op);
        case (op)
            OP_AND:                 return SEL_AND;
            OP_OR:                  return SEL_OR;
            OP_ADD, OP_SUB, OP_SLT: return SEL_SUM;
            default:                return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit ALU slice (AND/OR/full-adder select)
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic     a,
    input  logic     b,
    input  logic     b_invert,
    input  logic     carry_in,
    input  alu_sel_e sel,
    output logic     out,
    output logic     carry_out
);

    logic b_eff;

    // Full adder on the (optionally inverted) B bit, then pick the output function.
    always_comb begin
        b_eff     = b ^ b_invert;
        carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
        case (sel)
            SEL_AND: out = a & b;
            SEL_OR:  out = a | b;
            SEL_SUM: out = a ^ b_eff ^ carry_in;
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_sequencer.sv
// rtl/alu_serial_sequencer.sv - bit-serial ALU sequencer with start/busy/done handshake
module alu_serial_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    alu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;

    logic slice_out;
    logic slice_cout;

    // Operands are shifted right each RUN cycle, so the slice always sees bit 0.
    alu_bit_slice u_slice (
        .a         (opa_q[0]),
        .b         (opb_q[0]),
        .b_invert  (op_uses_sub(ctrl_q)),
        .carry_in  (carry_q),
        .sel       (op_to_sel(ctrl_q)),
        .out       (slice_out),
        .carry_out (slice_cout)
    );

    // Next-state and datapath: capture on start, one bit per RUN cycle, publish on entry to DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        ctrl_d     = ctrl_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        work_d     = work_q;
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    opa_d   = src1;
                    opb_d   = src2;
                    ctrl_d  = ctrl;
                    cnt_d   = '0;
                    carry_d = op_uses_sub(ctrl);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d  = {slice_out, work_q[WIDTH-1:1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    if (ctrl_q == OP_SLT) begin
                        state_d = ST_SLT_FIX;
                    end else begin
                        state_d    = ST_DONE;
                        result_d   = work_d;
                        zero_d     = (work_d == '0);
                        // carry_q is the carry into the MSB at this point
                        overflow_d = ((ctrl_q == OP_ADD) || (ctrl_q == OP_SUB))
                                     ? (carry_q ^ slice_cout) : 1'b0;
                    end
                end
            end
            ST_SLT_FIX: begin
                result_d   = {{(WIDTH-1){1'b0}}, work_q[WIDTH-1]};
                zero_d     = ~work_q[WIDTH-1];
                overflow_d = 1'b0;
                state_d    = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            ctrl_q     <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            work_q     <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            ctrl_q     <= ctrl_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            work_q     <= work_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == ST_RUN) || (state_q == ST_SLT_FIX);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb/tb_alu_serial_sequencer.sv - scoreboard bench for alu_serial_sequencer
module tb_alu_serial_sequencer;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    alu_serial_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ctrl     (ctrl),
        .src1     (src1),
        .src2     (src2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] r;
        logic v;
        r = '0;
        v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b110: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b111: begin
                r = a - b;
                r = {31'd0, r[31]};
            end
            default: r = '0;
        endcase
        e.res = r;
        e.zf  = (r == 32'd0);
        e.ovf = v;
        return e;
    endfunction

    // Compare each done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("zero", {31'd0, zero}, {31'd0, e.zf});
                check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            end
        end
    end

    // Drive start for one edge and push the expected outcome; returns #1 after E0.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ctrl  = op;
        src1  = a;
        src2  = b;
        start = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges from E0 until done, optionally pulsing a spurious start mid-run.
    task automatic wait_done(input string tag, input int exp_lat, input bit noise, output int busy_cnt);
        int cyc;
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            if (noise && cyc == 5) begin
                ctrl  = 3'b001;
                src1  = $urandom;
                src2  = $urandom;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check(tag, cyc, exp_lat);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int bc;
        @(posedge clk);
        #1;
        launch(op, a, b);
        wait_done(tag, (op == 3'b111) ? 34 : 33, 1'b0, bc);
    endtask

    initial begin
        int bc;
        int dcount;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = '0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        @(posedge clk);
        #1;
        launch(3'b010, 32'd5, 32'd7);
        wait_done("lat_add", 33, 1'b0, bc);
        check("busy_cycles", bc, 32);

        run_op("lat_sub_ovf", 3'b110, 32'h8000_0000, 32'd1);
        run_op("lat_sub_zero", 3'b110, 32'd9, 32'd9);
        run_op("lat_slt_neg", 3'b111, 32'hFFFF_FFFD, 32'd2);
        run_op("lat_slt_pos", 3'b111, 32'd2, 32'hFFFF_FFFD);
        run_op("lat_and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_op("lat_undef", 3'b011, 32'h1234_5678, 32'h1111_1111);
        run_op("lat_add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1);
        run_op("lat_or", 3'b001, 32'h0F00_0001, 32'h00F0_0100);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] ops[4];
            ops[0] = 3'b010; ops[1] = 3'b110; ops[2] = 3'b111; ops[3] = 3'b000;
            run_op("lat_rand", ops[i], $urandom, $urandom);
        end

        // spurious start while busy must not disturb the running op
        @(posedge clk);
        #1;
        launch(3'b010, 32'd100, 32'd23);
        wait_done("lat_noise", 33, 1'b1, bc);

        // back-to-back: start accepted in the DONE cycle
        launch(3'b110, 32'd50, 32'd8);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("lat_b2b", 33, 1'b0, bc);

        // reset in the middle of a run aborts with no done
        @(posedge clk);
        #1;
        launch(3'b010, 32'd3, 32'd4);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        rst = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("abort_no_done", dcount, 0);

        run_op("lat_after_rst", 3'b010, 32'hFFFF_FFFF, 32'd2);
        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
